// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset vector, NOP encoding, jump selects
// and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_JR  = 2'b01;
    localparam logic [1:0] JMP_J   = 2'b10;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: sequential pc+4 or the redirect target,
// with jr over j/jal over a taken branch.
module if_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [1:0]  jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic        take,
    output logic [31:0] target
);

    // Plain 32-bit add: the address wraps past 0xFFFF_FFFC by design.
    assign pc_plus4 = pc + 32'd4;
    assign take     = branch_taken | (jump != JMP_SEQ);

    // NOTE: every branch of this block assigns target, so no latch is inferred.
    always_comb begin
        if (jump == JMP_JR)
            target = jr_target;
        else if (jump == JMP_J)
            target = jump_target;
        else if (branch_taken)
            target = branch_target;
        else
            target = pc_plus4;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (FETCH/DROP/HOLD), hold buffer, IF/ID.
// Optional stall/flush counters when IF_STAGE_PERF_CNT_EN is defined.
module if_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        if_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [31:0] pc
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    logic         ifid_load;
    logic [31:0]  ifid_instr_d, ifid_pc4_d;
    logic         ifid_valid_d;

    logic         advance, redirect, squash, take;
    logic [31:0]  pc_plus4, target;

    if_next_pc u_next_pc (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .take          (take),
        .target        (target)
    );

    assign advance  = pc_write & ifid_write;
    assign redirect = advance & take;
    assign squash   = redirect & if_flush;

    assign pc        = pc_q;
    assign imem_req  = ~rst & (state_q != HOLD);
    // DROP keeps presenting the abandoned address until memory answers it.
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        drop_addr_d  = drop_addr_q;
        ifid_load    = 1'b0;
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = ifid_pc_plus4;
        ifid_valid_d = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (imem_ready && !advance) begin
                    hold_d  = imem_rdata;
                    state_d = HOLD;
                end else if (imem_ready) begin
                    ifid_load = 1'b1;
                    if (!squash) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                    pc_d = redirect ? target : pc_plus4;
                end else if (advance) begin
                    ifid_load = 1'b1;
                    if (redirect) begin
                        pc_d        = target;
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end
            end

            DROP: begin
                if (advance) begin
                    ifid_load = 1'b1;
                    if (redirect)
                        pc_d = target;
                end
                if (imem_ready)
                    state_d = FETCH;
            end

            HOLD: begin
                if (advance) begin
                    ifid_load = 1'b1;
                    if (!squash) begin
                        ifid_instr_d = hold_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                    pc_d    = redirect ? target : pc_plus4;
                    hold_d  = NOP_INSTR;
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            // NOTE: the hold buffer is reset too, so a stale word can never
            // surface after reset even though it is only a data register.
            hold_q      <= NOP_INSTR;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (ifid_load) begin
            ifid_instr    <= ifid_instr_d;
            ifid_pc_plus4 <= ifid_pc4_d;
            ifid_valid    <= ifid_valid_d;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!advance && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (squash && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, ifid_write, if_flush, branch_taken;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [1:0]  jump;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifid_instr, ifid_pc_plus4, pc;
    logic        ifid_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .if_flush      (if_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .pc            (pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: the memory returns each word equal to its address.
    // held[] holds a fetched word waiting for the pipeline; discarding marks
    // an abandoned request whose answer must be thrown away.
    logic [31:0] m_pc, m_old_addr;
    logic [31:0] held[$];
    bit          discarding;
    logic [31:0] m_instr, m_pc4;
    bit          m_valid;

    function automatic void present(bit valid, logic [31:0] word, logic [31:0] pc4);
        if (valid) begin
            m_instr = word; m_pc4 = pc4; m_valid = 1'b1;
        end else begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit          adv, redir, squash;
        logic [31:0] tgt, word;
        adv    = pc_write && ifid_write;
        redir  = adv && (branch_taken || jump != 2'b00);
        squash = redir && if_flush;
        tgt    = (jump == 2'b01) ? jr_target :
                 (jump == 2'b10) ? jump_target :
                 branch_taken    ? branch_target : m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0; held.delete(); discarding = 1'b0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (held.size() != 0) begin
            if (adv) begin
                word = held.pop_front();
                present(!squash, word, m_pc + 32'd4);
                m_pc = redir ? tgt : m_pc + 32'd4;
            end
        end else if (discarding) begin
            if (adv) begin
                present(1'b0, 32'h0, 32'h0);
                if (redir) m_pc = tgt;
            end
            if (imem_ready) discarding = 1'b0;
        end else if (imem_ready) begin
            if (!adv) held.push_back(m_pc);
            else begin
                present(!squash, m_pc, m_pc + 32'd4);
                m_pc = redir ? tgt : m_pc + 32'd4;
            end
        end else if (adv) begin
            present(1'b0, 32'h0, 32'h0);
            if (redir) begin
                m_old_addr = m_pc; discarding = 1'b1; m_pc = tgt;
            end
        end
    endfunction

    // One clock: check the request mid-cycle, advance the model, check state after the edge.
    task automatic cycle();
        bit exp_req;
        @(negedge clk);
        imem_rdata = imem_addr;
        exp_req = !rst && held.size() == 0;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, discarding ? m_old_addr : m_pc);
        model_step();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        check("ifid_instr", ifid_instr, m_instr);
        if (m_valid) check("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
    endtask

    task automatic set_idle();
        rst = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; if_flush = 1'b0;
        branch_taken = 1'b0; jump = 2'b00; imem_ready = 1'b1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
        imem_rdata = 32'h0;
        m_pc = 32'h0; m_old_addr = 32'h0; discarding = 1'b0;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;

        // Reset state, then streaming sequential fetch.
        repeat (2) cycle();
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'b0, ifid_valid}, 32'h0);
        set_idle();
        cycle(); check("seq_pc4_0", ifid_pc_plus4, 32'd4);
        cycle(); check("seq_pc4_1", ifid_pc_plus4, 32'd8);
        cycle(); check("seq_pc4_2", ifid_pc_plus4, 32'd12);
        check("seq_valid", {31'b0, ifid_valid}, 32'h1);
        cycle();
        check("pc_at_0x10", pc, 32'h10);

        // Stall with data ready at 0x10: word is parked, IF/ID frozen.
        pc_write = 1'b0; ifid_write = 1'b0;
        repeat (3) cycle();
        check("hold_req_low", {31'b0, imem_req}, 32'h0);
        check("hold_frozen_instr", ifid_instr, 32'h0000_000C);
        set_idle();
        cycle();
        check("hold_release_instr", ifid_instr, 32'h10);
        check("hold_release_pc", pc, 32'h14);

        // jr with flush while memory is busy: DROP, bubble, then 0x40.
        imem_ready = 1'b0; jump = 2'b01; jr_target = 32'h40; if_flush = 1'b1;
        cycle();
        set_idle(); imem_ready = 1'b0;
        cycle();
        check("drop_old_addr", imem_addr, 32'h14);
        imem_ready = 1'b1;
        cycle();
        check("drop_bubble", {31'b0, ifid_valid}, 32'h0);
        cycle();
        check("drop_target_instr", ifid_instr, 32'h40);

        // Target priority.
        branch_taken = 1'b1; branch_target = 32'h100; jump = 2'b10; jump_target = 32'h200;
        if_flush = 1'b1;
        cycle();
        check("prio_j_over_beq", pc, 32'h200);
        jump = 2'b01; jr_target = 32'h300;
        cycle();
        check("prio_jr_over_beq", pc, 32'h300);

        // Wrap past the top of the address space.
        set_idle(); jump = 2'b10; jump_target = 32'hFFFF_FFFC;
        cycle();
        set_idle();
        cycle();
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", ifid_pc_plus4, 32'h0);

        // Reset during DROP, with the late answer arriving under reset.
        imem_ready = 1'b0; jump = 2'b01; jr_target = 32'h80;
        cycle();
        set_idle(); rst = 1'b1; imem_ready = 1'b1;
        cycle();
        set_idle(); imem_ready = 1'b0;
        @(negedge clk);
        check("post_rst_req", {31'b0, imem_req}, 32'h1);
        check("post_rst_addr", imem_addr, 32'h0);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit ctl;
            rst          = ($urandom_range(99) < 1);
            pc_write     = ($urandom_range(99) < 85);
            ifid_write   = ($urandom_range(99) < 85);
            imem_ready   = ($urandom_range(99) < 60);
            branch_taken = ($urandom_range(99) < 15);
            case ($urandom_range(9))
                0:       jump = 2'b01;
                1:       jump = 2'b10;
                default: jump = 2'b00;
            endcase
            ctl           = branch_taken || jump != 2'b00;
            if_flush      = ctl && $urandom_range(1) == 1;
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            jr_target     = $urandom & 32'hFFFF_FFFC;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 pc_write  in  1  hazard unit; 1 = PC may advance.
REQ-004 ifid_write  in  1  hazard unit; 1 = IF/ID register may load.
REQ-005 if_flush  in  1  control unit; squash the instruction being fetched.
REQ-006 branch_taken  in  1  taken beq resolved in ID.
REQ-007 branch_target  in  32  beq target address.
REQ-008 jump  in  2  00 sequential, 01 jr, 10 j/jal.
REQ-009 jump_target  in  32  j/jal target address.
REQ-010 jr_target  in  32  register value for jr.
REQ-011 imem_req / imem_addr  out  1 / 32  instruction memory request and word address.
REQ-012 imem_ready / imem_rdata  in  1 / 32  memory completion and fetched word.
REQ-013 ifid_instr / ifid_pc_plus4 / ifid_valid  out  32 / 32 / 1  IF/ID pipeline register.
REQ-014 pc  out  32  current fetch PC.

Function
REQ-015 advance SHALL equal pc_write & ifid_write.
REQ-016 redirect SHALL equal advance & (branch_taken | jump != 00); target priority: jr_target (01) > jump_target (10) > branch_target > pc+4.
REQ-017 FSM states SHALL be FETCH, DROP and HOLD.
REQ-018 FETCH: imem_req=1 and imem_addr=pc; address stays stable until imem_ready.
REQ-019 FETCH, imem_ready=1, advance=1, no redirect: IF/ID loads {rdata, pc+4, valid=1} at the next edge; pc <= pc+4; stay in FETCH. Latency is one cycle from ready to ifid_valid.
REQ-020 FETCH, imem_ready=1, advance=0: rdata is captured into the hold buffer; go to HOLD; imem_req=0; IF/ID and pc are unchanged.
REQ-021 HOLD: on advance, IF/ID loads from the hold buffer; pc <= pc+4; return to FETCH.
REQ-022 A redirect in any state SHALL: load pc with the target; load IF/ID with the NOP bubble (instr=0, valid=0) when if_flush=1; and discard the hold buffer.
REQ-023 A redirect in FETCH with imem_ready=0 SHALL latch the target and enter DROP. In DROP, imem_req and the old address are held until imem_ready; that data is discarded; the state then returns to FETCH at the latched target.
REQ-024 advance=0 SHALL ignore redirect and if_flush; the ID instruction is re-presented next cycle.
REQ-025 FETCH, imem_ready=0, advance=1, no redirect: IF/ID loads the bubble (valid=0).
REQ-026 pc+4 SHALL wrap modulo 2^32 with no error.

Reset
REQ-027 While rst=1: pc=RESET_PC (32'h0000_0000), ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, imem_req=0, hold buffer cleared, state FETCH.
REQ-028 imem_req SHALL rise on the first cycle after rst deasserts.
REQ-029 rst asserted during DROP or HOLD SHALL abandon the outstanding transaction; any later imem_ready for it is ignored until the first post-reset request.

Configuration
REQ-030 With IF_STAGE_PERF_CNT_EN defined: add outputs stall_cnt[31:0] (cycles with advance=0) and flush_cnt[31:0] (bubbles from if_flush). Both saturate at 32'hFFFF_FFFF and clear on rst.
REQ-031 Without IF_STAGE_PERF_CNT_EN: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-032 The shared package mips_pkg SHALL hold: RESET_PC, NOP_INSTR (32'h0), jump encodings JMP_SEQ/JMP_JR/JMP_J, and the fetch-state enum.
REQ-033 Next-PC selection SHALL be a combinational sub-module, if_next_pc, instantiated once.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset, then imem_ready=1 each cycle with rdata = address: ifid_pc_plus4 = 4, 8, 12 on consecutive cycles; ifid_valid=1 from cycle 2.
- pc_write=ifid_write=0 for 3 cycles with ready at pc=0x10: state HOLD; IF/ID frozen; on release ifid_instr=0x10 and pc=0x14.
- jump=01, jr_target=0x40, if_flush=1 while ready=0: DROP; the old word is discarded; the next IF/ID holds the bubble, then the instruction at 0x40.
- branch_taken=1 and jump=10 together: jump_target wins; branch_taken and jump=01 together: jr_target wins.
- pc=0xFFFF_FFFC, sequential fetch: pc wraps to 0x0000_0000.
- rst pulsed during DROP: the late imem_ready is ignored; the first request after reset targets 0x0.
